pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, DM, WB).
- Detects load-use hazards between the ID and ID/EX stages.
- Squashes wrong-path instructions on a taken branch resolved in EX.
- Freezes the back end while a multi-cycle data-memory access is outstanding.
- Drives the write-enable, flush and hold controls of the PC and of the IF_ID, ID_EX, EX_DM and DM_WB registers, and keeps stall statistics and a memory-timeout flag.

Parameters:
REG_ADDR_W, 5, width of register-file addresses
MEM_TIMEOUT, 15, consecutive MEM_WAIT cycles after which timeout_err sets (1..255)
CNT_W, 16, width of the stall_cycles counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs  in  REG_ADDR_W  rs field of the instruction in ID
id_rt  in  REG_ADDR_W  rt field of the instruction in ID
id_uses_rt  in  1  instruction in ID reads rt as a source
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rt  in  REG_ADDR_W  destination (rt) of the load in EX
ex_branch_taken  in  1  branch in EX resolved taken this cycle
dm_req  in  1  EX_DM holds a valid load/store
dm_ready  in  1  data memory completes the access this cycle
pc_write_en  out  1  PC may update
if_id_write_en  out  1  IF_ID may load
if_id_flush  out  1  IF_ID loads a NOP
id_ex_bubble  out  1  ID_EX loads a NOP (all control bits 0)
id_ex_hold  out  1  ID_EX retains its contents
ex_dm_hold  out  1  EX_DM retains its contents
dm_wb_bubble  out  1  DM_WB loads a NOP (reg_write=0)
ctrl_state  out  2  current state: RUN=0, LOAD_STALL=1, MEM_WAIT=2
stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en=0
timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (asynchronous): state=RUN, stall_cycles=0, timeout_err=0, wait_cnt=0.
  - While reset is high, every control output is 0. No register updates; the pipeline is idle.
- Hazard terms (combinational):
  - mem_stall = dm_req & ~dm_ready
  - load_use = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == id_rs) | (id_uses_rt & id_ex_rt == id_rt))
- Outputs are Mealy (current state plus inputs) with zero-cycle latency. Priority: mem_stall > ex_branch_taken > load_use > normal.
- mem_stall, any state:
  - pc_write_en=0, if_id_write_en=0, id_ex_hold=1, ex_dm_hold=1, dm_wb_bubble=1; if_id_flush=0, id_ex_bubble=0.
  - Next state=MEM_WAIT. A concurrent branch or load-use is ignored this cycle; ID_EX is frozen, so it re-presents when the stall ends.
- ex_branch_taken (no mem_stall):
  - pc_write_en=1 (PC loads the branch target), if_id_write_en=1, if_id_flush=1, id_ex_bubble=1; holds 0.
  - Next state=RUN. A load-use hazard in the same cycle is discarded because the ID instruction is squashed.
- load_use in RUN (no mem_stall, no branch):
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; other outputs 0.
  - Next state=LOAD_STALL.
- LOAD_STALL: load_use detection is suppressed (ID_EX holds the bubble). Outputs are as normal. Next state=RUN.
- Normal: pc_write_en=1, if_id_write_en=1; all others 0. Next state=RUN.
- MEM_WAIT:
  - wait_cnt increments each cycle mem_stall stays high, saturating at 255.
  - When wait_cnt reaches MEM_TIMEOUT, timeout_err sets and stays set until reset. Stalling continues regardless.
  - When mem_stall drops: wait_cnt clears, the current-cycle priority rules apply, and the state becomes RUN (or LOAD_STALL if load_use wins).
- stall_cycles increments on every rising edge with reset low and pc_write_en=0. It saturates at all-ones.
- Reset mid-stall: outputs drop to 0 immediately; state returns to RUN with no residual hold.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=8, id_rs=8 → 1 cycle with pc_write_en=0, id_ex_bubble=1, ctrl_state→1; next cycle normal; stall_cycles=1.
- No hazard on $0 or unused rt: id_ex_rt=0 with id_rs=0 gives no stall. Separately, id_ex_rt=9, id_rt=9, id_uses_rt=0 gives no stall.
- Branch beats load-use: ex_branch_taken=1 and load_use=1 together → if_id_flush=1, id_ex_bubble=1, pc_write_en=1, state stays RUN, stall_cycles unchanged.
- Memory wait: dm_req=1, dm_ready=0 for 3 cycles, then dm_ready=1 → ex_dm_hold=1 and dm_wb_bubble=1 for exactly 3 cycles, ctrl_state=2, stall_cycles=3, then RUN.
- Timeout: MEM_TIMEOUT=4, dm_ready held 0 for 6 cycles → timeout_err rises after the 4th wait cycle and stays 1 after dm_ready=1, until reset.
- Asynchronous reset asserted mid-MEM_WAIT (between edges) → all outputs 0 immediately, ctrl_state=0, stall_cycles=0, timeout_err=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken-branch
// squash and back-end freeze during multi-cycle data-memory accesses.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  dm_req,
  input  logic                  dm_ready,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  id_ex_hold,
  output logic                  ex_dm_hold,
  output logic                  dm_wb_bubble,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [7:0] LP_TIMEOUT  = 8'(MEM_TIMEOUT);
  localparam logic [7:0] LP_WAIT_MAX = 8'hFF;

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_timeout_err;

  logic             w_mem_stall;
  logic             w_load_use;
  logic             w_load_use_act;
  state_t           w_next_state;
  logic [7:0]       w_wait_cnt_nxt;
  logic             w_pc_write_en;
  logic             w_if_id_write_en;
  logic             w_if_id_flush;
  logic             w_id_ex_bubble;
  logic             w_id_ex_hold;
  logic             w_ex_dm_hold;
  logic             w_dm_wb_bubble;

  assign w_mem_stall = dm_req & ~dm_ready;
  assign w_load_use  = id_ex_mem_read & (id_ex_rt != '0) &
                       ((id_ex_rt == id_rs) | (id_uses_rt & (id_ex_rt == id_rt)));
  // ID_EX already carries the bubble in LOAD_STALL, so the same hazard must not re-trigger.
  assign w_load_use_act = w_load_use & (r_state != ST_LOAD_STALL);

  always_comb begin
    w_pc_write_en    = 1'b0;
    w_if_id_write_en = 1'b0;
    w_if_id_flush    = 1'b0;
    w_id_ex_bubble   = 1'b0;
    w_id_ex_hold     = 1'b0;
    w_ex_dm_hold     = 1'b0;
    w_dm_wb_bubble   = 1'b0;
    w_next_state     = ST_RUN;
    if (reset) begin
      w_next_state = ST_RUN;
    end else if (w_mem_stall) begin
      w_id_ex_hold   = 1'b1;
      w_ex_dm_hold   = 1'b1;
      w_dm_wb_bubble = 1'b1;
      w_next_state   = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      w_pc_write_en    = 1'b1;
      w_if_id_write_en = 1'b1;
      w_if_id_flush    = 1'b1;
      w_id_ex_bubble   = 1'b1;
      w_next_state     = ST_RUN;
    end else if (w_load_use_act) begin
      w_id_ex_bubble = 1'b1;
      w_next_state   = ST_LOAD_STALL;
    end else begin
      w_pc_write_en    = 1'b1;
      w_if_id_write_en = 1'b1;
      w_next_state     = ST_RUN;
    end
  end

  always_comb begin
    w_wait_cnt_nxt = '0;
    if (w_mem_stall) begin
      w_wait_cnt_nxt = (r_wait_cnt == LP_WAIT_MAX) ? LP_WAIT_MAX : r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_mem_stall && (w_wait_cnt_nxt == LP_TIMEOUT)) begin
        r_timeout_err <= 1'b1;
      end
      if (!w_pc_write_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign pc_write_en    = w_pc_write_en;
  assign if_id_write_en = w_if_id_write_en;
  assign if_id_flush    = w_if_id_flush;
  assign id_ex_bubble   = w_id_ex_bubble;
  assign id_ex_hold     = w_id_ex_hold;
  assign ex_dm_hold     = w_ex_dm_hold;
  assign dm_wb_bubble   = w_dm_wb_bubble;
  assign ctrl_state     = r_state;
  assign stall_cycles   = r_stall_cycles;
  assign timeout_err    = r_timeout_err;

endmodule
